// File: rtl/iterative_rotator_ctrl.sv
// Iterative circular rotator controller.
// One fixed-stage rotate unit is reused once per shift-amount bit. Step k
// rotates the held word by 2^k when bit k of the captured amount is set, so
// every operation takes exactly SHAMT_W rotate cycles whatever the amount.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload steady while valid is high and
// ready is low. up_rdy is high only in IDLE. down_vld is high only in DONE,
// and down_data is held steady until the edge that sees down_rdy.
module iterative_rotator_ctrl #(
  parameter int W       = 8,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_vld,
  output logic               up_rdy,
  input  logic [W-1:0]       up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic               up_dir,
  output logic               down_vld,
  input  logic               down_rdy,
  output logic [W-1:0]       down_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] K_ONE  = SHAMT_W'(1);

  state_t             state_q;
  logic [W-1:0]       data_q;
  logic [SHAMT_W-1:0] shamt_q;   // shifted right each step; bit 0 is the live amount bit
  logic               dir_q;
  logic [SHAMT_W-1:0] k_q;
  logic               up_rdy_q;
  logic               down_vld_q;
  logic [W-1:0]       down_data_q;
  logic               busy_q;

  int unsigned        step_amt;
  logic [W-1:0]       rot_l;
  logic [W-1:0]       rot_r;
  logic [W-1:0]       data_d;

  // Shared rotate stage: rotate the held word by 2^k when the current amount bit is set.
  always_comb begin
    step_amt = 32'd1 << k_q;
    rot_l    = (data_q << step_amt) | (data_q >> (W - step_amt));
    rot_r    = (data_q >> step_amt) | (data_q << (W - step_amt));
    data_d   = data_q;
    if (shamt_q[0]) begin
      data_d = dir_q ? rot_r : rot_l;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      shamt_q     <= '0;
      dir_q       <= 1'b0;
      k_q         <= '0;
      up_rdy_q    <= 1'b1;
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (up_vld && up_rdy_q) begin
            data_q   <= up_data;
            shamt_q  <= up_shamt;
            dir_q    <= up_dir;
            k_q      <= '0;
            up_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          data_q  <= data_d;
          shamt_q <= shamt_q >> 1;
          k_q     <= k_q + K_ONE;
          if (k_q == K_LAST) begin
            down_data_q <= data_d;
            down_vld_q  <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (down_rdy) begin
            down_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            up_rdy_q   <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          down_vld_q <= 1'b0;
          busy_q     <= 1'b0;
          up_rdy_q   <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign up_rdy    = up_rdy_q;
  assign down_vld  = down_vld_q;
  assign down_data = down_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iterative_rotator_ctrl.sv
// Bench for iterative_rotator_ctrl (W=8): directed vector table, backpressure,
// abort and randomized back-to-back operations against a bit-mapping model.
module tb_iterative_rotator_ctrl;

  localparam int W  = 8;
  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_vld = 1'b0;
  logic          up_rdy;
  logic [W-1:0]  up_data = '0;
  logic [SW-1:0] up_shamt = '0;
  logic          up_dir = 1'b0;
  logic          down_vld;
  logic          down_rdy = 1'b1;
  logic [W-1:0]  down_data;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  iterative_rotator_ctrl #(.W(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld),
    .up_rdy    (up_rdy),
    .up_data   (up_data),
    .up_shamt  (up_shamt),
    .up_dir    (up_dir),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_data (down_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int acc_cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: map each input bit straight to its rotated position.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int s, input logic dir);
    logic [W-1:0] r;
    int sl;
    sl = dir ? (W - s) % W : s;
    r = '0;
    for (int i = 0; i < W; i++) r[(i + sl) % W] = d[i];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, waits for the result and checks latency and data.
  // Leaves the bench #1 after the edge where down_vld was first seen.
  task automatic do_op(input logic [W-1:0] d, input logic [SW-1:0] s, input logic dr,
                       input logic [W-1:0] exp, input string tag);
    int cnt;
    cnt = 0;
    while (!up_rdy && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    if (!up_rdy) begin
      n_vec++; n_err++;
      $display("FAIL %s_up_rdy_timeout: up_rdy stayed 0 for %0d cycles", tag, cnt);
      return;
    end
    up_vld = 1'b1; up_data = d; up_shamt = s; up_dir = dr;
    @(posedge clk); #1;
    acc_cycle = cycle;
    up_vld = 1'b0; up_data = W'($urandom); up_shamt = SW'($urandom); up_dir = 1'($urandom);
    exp_q.push_back(exp);
    check({tag, "_busy_rot"}, {31'd0, busy}, 32'd1);
    check({tag, "_up_rdy_rot"}, {31'd0, up_rdy}, 32'd0);
    cnt = 0;
    while (!down_vld && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    if (!down_vld) begin
      n_vec++; n_err++;
      $display("FAIL %s_down_vld_timeout: no result after %0d cycles", tag, cnt);
      void'(exp_q.pop_front());
      return;
    end
    check({tag, "_latency"}, cnt, SW);
    check({tag, "_data"}, {24'd0, down_data}, {24'd0, exp_q.pop_front()});
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic          dir;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] d;
    logic [SW-1:0] s;
    logic dr;
    int prev_acc;
    int seen;

    vecs[0] = '{8'hA3, 3'd3, 1'b1, 8'h74};
    vecs[1] = '{8'hA3, 3'd3, 1'b0, 8'h1D};
    vecs[2] = '{8'hA3, 3'd7, 1'b0, 8'hD1};
    vecs[3] = '{8'hA3, 3'd1, 1'b1, 8'hD1};
    vecs[4] = '{8'hA3, 3'd0, 1'b0, 8'hA3};
    vecs[5] = '{8'hA3, 3'd0, 1'b1, 8'hA3};
    vecs[6] = '{8'h81, 3'd1, 1'b0, 8'h03};
    vecs[7] = '{8'hF0, 3'd4, 1'b1, 8'h0F};
    vecs[8] = '{8'h96, 3'd2, 1'b0, 8'h5A};

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_up_rdy", {31'd0, up_rdy}, 32'd1);
    check("rst_down_vld", {31'd0, down_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_down_data", {24'd0, down_data}, 32'd0);

    // directed table
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].data, vecs[i].shamt, vecs[i].dir, vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(posedge clk); #1;

    // backpressure: result held for 5 cycles, then released
    down_rdy = 1'b0;
    do_op(8'h5C, 3'd5, 1'b1, ref_rot(8'h5C, 5, 1'b1), "bp");
    held = down_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_vld_hold", {31'd0, down_vld}, 32'd1);
      check("bp_data_hold", {24'd0, down_data}, {24'd0, held});
      check("bp_up_rdy", {31'd0, up_rdy}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    down_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vld", {31'd0, down_vld}, 32'd0);
    check("bp_rel_up_rdy", {31'd0, up_rdy}, 32'd1);
    check("bp_rel_busy", {31'd0, busy}, 32'd0);

    // abort: reset during the second rotate cycle
    up_vld = 1'b1; up_data = 8'hA3; up_shamt = 3'd3; up_dir = 1'b1;
    @(posedge clk); #1;
    up_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_up_rdy", {31'd0, up_rdy}, 32'd1);
    check("abort_down_vld", {31'd0, down_vld}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (down_vld) seen++;
    end
    check("abort_no_result", seen, 0);

    // randomized back-to-back ops
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      d  = W'($urandom);
      s  = SW'($urandom_range(0, W - 1));
      dr = 1'($urandom);
      do_op(d, s, dr, ref_rot(d, int'(s), dr), $sformatf("rnd%0d", i));
      if (i > 0) check($sformatf("rnd%0d_spacing", i), acc_cycle - prev_acc, 5);
      prev_acc = acc_cycle;
    end
    @(posedge clk); #1;
    check("end_idle_up_rdy", {31'd0, up_rdy}, 32'd1);
    check("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
